// File: rtl/uniboard_pkg.sv
// Shared definitions for the uniboard command path.
//   CHAR_START / CHAR_END / CHAR_ESC : framing characters on the serial link
//   REG_ADDR_W                       : peripheral register address width
//   seq_state_t                      : command sequencer state encoding
package uniboard_pkg;

  localparam logic [7:0] CHAR_START = 8'h01;
  localparam logic [7:0] CHAR_END   = 8'h17;
  localparam logic [7:0] CHAR_ESC   = 8'h1B;

  localparam int REG_ADDR_W = 7;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_WDATA  = 4'd2,
    ST_RCOUNT = 4'd3,
    ST_RWAIT  = 4'd4,
    ST_RSTART = 4'd5,
    ST_RREAD  = 4'd6,
    ST_RDATA  = 4'd7,
    ST_REND   = 4'd8
  } seq_state_t;

endpackage

// File: rtl/uniboard_cmd_sequencer_if.sv
// Bus bundle around the command sequencer.
//   Decoder side : dec_drdy, dec_data, dec_start, dec_end
//   Register bus : reg_addr, reg_wdata, reg_we, reg_re, reg_rdata
//   Transmit     : tx_data, tx_esc, tx_valid, tx_ready
// Modports:
//   master : the sequencer (drives register bus and transmit request)
//   slave  : decoder / register file / transmit encoder side
interface uniboard_cmd_sequencer_if;
  import uniboard_pkg::*;

  logic                  dec_drdy;
  logic [7:0]            dec_data;
  logic                  dec_start;
  logic                  dec_end;

  logic [REG_ADDR_W-1:0] reg_addr;
  logic [7:0]            reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [7:0]            reg_rdata;

  logic [7:0]            tx_data;
  logic                  tx_esc;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  dec_drdy, dec_data, dec_start, dec_end,
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata,
    output tx_data, tx_esc, tx_valid,
    input  tx_ready
  );

  modport slave (
    output dec_drdy, dec_data, dec_start, dec_end,
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata,
    input  tx_data, tx_esc, tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uniboard_edge_detect.sv
// Rising-edge pulse generator, one lane per bit.
//   clk, reset : clock, synchronous active-high reset
//   sig_in     : level inputs
//   rise       : one-cycle pulse in the cycle a lane goes 0 -> 1
// A lane held high produces exactly one pulse.
module uniboard_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] rise
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      logic prev_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          prev_reg <= 1'b0;
        end else begin
          prev_reg <= sig_in[gi];
        end
      end

      assign rise[gi] = sig_in[gi] & ~prev_reg;
    end
  endgenerate

endmodule

// File: rtl/uniboard_cmd_sequencer.sv
// Command sequencer: parses framed commands from the character decoder,
// issues register writes/reads and sends framed read responses.
//   clk, reset : clock, synchronous active-high reset
//   bus        : decoder, register bus and transmit signals (master side)
//   busy       : high whenever the sequencer is not idle
//   frame_err  : one-cycle pulse on a protocol error
// Frame: START, CMD (bit7 = read, bits6:0 = start address), payload, END.
// Optional build macro UNIBOARD_CMD_TIMEOUT_EN adds an inter-character
// timeout (TIMEOUT_CYCLES) that abandons partial frames.
module uniboard_cmd_sequencer
  import uniboard_pkg::*;
#(
  parameter int MAX_READ       = 16,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic                       clk,
  input  logic                       reset,
  uniboard_cmd_sequencer_if.master   bus,
  output logic                       busy,
  output logic                       frame_err
);

  localparam int CNT_W = $clog2(MAX_READ + 1);

  seq_state_t            state_reg, state_next;
  logic [REG_ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  we_reg, we_next;
  logic [7:0]            wdata_reg, wdata_next;
  logic [7:0]            rbuf_reg, rbuf_next;
  logic                  rd_phase_reg, rd_phase_next;
  logic                  frame_err_reg, frame_err_next;

  logic                  tx_valid_c;
  logic [7:0]            tx_data_c;
  logic                  tx_esc_c;
  logic                  reg_re_c;

  logic                  char_ev;
  logic                  is_start, is_end, is_byte;
  logic                  in_parse;
  logic                  timeout_hit;
  logic [CNT_W-1:0]      count_clamped;

  uniboard_edge_detect #(.WIDTH(1)) u_drdy_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_in (bus.dec_drdy),
    .rise   (char_ev)
  );

  // START wins over END if the decoder ever flags both.
  assign is_start = char_ev & bus.dec_start;
  assign is_end   = char_ev & bus.dec_end & ~bus.dec_start;
  assign is_byte  = char_ev & ~bus.dec_start & ~bus.dec_end;

  assign in_parse = (state_reg == ST_CMD)    || (state_reg == ST_WDATA) ||
                    (state_reg == ST_RCOUNT) || (state_reg == ST_RWAIT);

  assign count_clamped = (int'(bus.dec_data) > MAX_READ) ? CNT_W'(MAX_READ)
                                                         : CNT_W'(bus.dec_data);

`ifdef UNIBOARD_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_reg;

  // Counts idle cycles within a partial frame; cleared by any character
  // and whenever the sequencer is outside the parse states.
  always_ff @(posedge clk) begin
    if (reset || char_ev || !in_parse) begin
      to_cnt_reg <= '0;
    end else if (!timeout_hit) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

  assign timeout_hit = in_parse && !char_ev &&
                       (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      rbuf_reg      <= '0;
      rd_phase_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      cnt_reg       <= cnt_next;
      we_reg        <= we_next;
      wdata_reg     <= wdata_next;
      rbuf_reg      <= rbuf_next;
      rd_phase_reg  <= rd_phase_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    // The write address advances in the cycle its strobe is on the bus,
    // so reg_addr still shows the written address during reg_we.
    addr_next      = we_reg ? addr_reg + REG_ADDR_W'(1) : addr_reg;
    cnt_next       = cnt_reg;
    we_next        = 1'b0;
    wdata_next     = wdata_reg;
    rbuf_next      = rbuf_reg;
    rd_phase_next  = 1'b0;
    frame_err_next = 1'b0;
    tx_valid_c     = 1'b0;
    tx_data_c      = 8'h00;
    tx_esc_c       = 1'b0;
    reg_re_c       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (is_start) state_next = ST_CMD;
      end

      ST_CMD: begin
        if (is_start) begin
          frame_err_next = 1'b1;
        end else if (is_end) begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end else if (is_byte) begin
          addr_next  = bus.dec_data[REG_ADDR_W-1:0];
          state_next = bus.dec_data[7] ? ST_RCOUNT : ST_WDATA;
        end
      end

      ST_WDATA: begin
        if (is_start) begin
          frame_err_next = 1'b1;
          state_next     = ST_CMD;
        end else if (is_end) begin
          state_next = ST_IDLE;
        end else if (is_byte) begin
          we_next    = 1'b1;
          wdata_next = bus.dec_data;
        end
      end

      ST_RCOUNT: begin
        if (is_start) begin
          frame_err_next = 1'b1;
          state_next     = ST_CMD;
        end else if (is_end) begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end else if (is_byte) begin
          cnt_next   = count_clamped;
          state_next = ST_RWAIT;
        end
      end

      ST_RWAIT: begin
        if (is_start) begin
          frame_err_next = 1'b1;
          state_next     = ST_CMD;
        end else if (is_end) begin
          state_next = ST_RSTART;
        end else if (is_byte) begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      ST_RSTART: begin
        tx_valid_c     = 1'b1;
        tx_data_c      = CHAR_START;
        frame_err_next = char_ev;
        if (bus.tx_ready) begin
          state_next = (cnt_reg == '0) ? ST_REND : ST_RREAD;
        end
      end

      // Two cycles: strobe reg_re, then capture reg_rdata.
      ST_RREAD: begin
        frame_err_next = char_ev;
        if (!rd_phase_reg) begin
          reg_re_c      = 1'b1;
          rd_phase_next = 1'b1;
        end else begin
          rbuf_next  = bus.reg_rdata;
          state_next = ST_RDATA;
        end
      end

      ST_RDATA: begin
        tx_valid_c     = 1'b1;
        tx_data_c      = rbuf_reg;
        tx_esc_c       = 1'b1;
        frame_err_next = char_ev;
        if (bus.tx_ready) begin
          addr_next  = addr_reg + REG_ADDR_W'(1);
          cnt_next   = cnt_reg - CNT_W'(1);
          state_next = (cnt_reg == CNT_W'(1)) ? ST_REND : ST_RREAD;
        end
      end

      ST_REND: begin
        tx_valid_c     = 1'b1;
        tx_data_c      = CHAR_END;
        frame_err_next = char_ev;
        if (bus.tx_ready) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase

    if (timeout_hit) begin
      state_next     = ST_IDLE;
      frame_err_next = 1'b1;
    end
  end

  // Gating with reset drops the transmit request in the reset cycle itself.
  assign bus.tx_valid  = tx_valid_c & ~reset;
  assign bus.tx_data   = tx_data_c;
  assign bus.tx_esc    = tx_esc_c;
  assign bus.reg_re    = reg_re_c & ~reset;
  assign bus.reg_we    = we_reg;
  assign bus.reg_wdata = wdata_reg;
  assign bus.reg_addr  = addr_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign frame_err     = frame_err_reg;

endmodule

// File: tb/tb_uniboard_cmd_sequencer.sv
// Scoreboard bench for uniboard_cmd_sequencer.
module tb_uniboard_cmd_sequencer;

`ifdef UNIBOARD_CMD_TIMEOUT_EN
  localparam int TB_TIMEOUT = 100;
`else
  localparam int TB_TIMEOUT = 120000;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic frame_err;

  always #5 clk = ~clk;

  uniboard_cmd_sequencer_if bus_if ();

  uniboard_cmd_sequencer #(
    .MAX_READ       (16),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.master),
    .busy      (busy),
    .frame_err (frame_err)
  );

  int total = 0;
  int bad   = 0;
  int we_cnt = 0, re_cnt = 0, tx_cnt = 0, err_cnt = 0;

  logic [15:0] wr_q[$];   // {addr, data}
  logic [8:0]  tx_q[$];   // {esc, data}
  logic [7:0]  regs [0:127];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Register file model: read data appears the cycle after reg_re.
  always @(posedge clk) begin
    if (bus_if.reg_re) bus_if.reg_rdata <= regs[bus_if.reg_addr];
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.reg_we && bus_if.reg_re) chk("we_re_excl", 32'(bus_if.reg_re), 0);
      if (bus_if.reg_re) re_cnt++;
      if (frame_err) err_cnt++;
      if (bus_if.reg_we) begin
        we_cnt++;
        if (wr_q.size() == 0) begin
          chk("wr_unexpected_qsize", 32'(wr_q.size()), 1);
        end else begin
          logic [15:0] e;
          e = wr_q.pop_front();
          $display("write addr=0x%02h data=0x%02h", bus_if.reg_addr, bus_if.reg_wdata);
          chk("wr_addr", 32'(bus_if.reg_addr), 32'(e[14:8]));
          chk("wr_data", 32'(bus_if.reg_wdata), 32'(e[7:0]));
        end
      end
      if (bus_if.tx_valid && bus_if.tx_ready) begin
        tx_cnt++;
        if (tx_q.size() == 0) begin
          chk("tx_unexpected_qsize", 32'(tx_q.size()), 1);
        end else begin
          logic [8:0] e;
          e = tx_q.pop_front();
          $display("tx data=0x%02h esc=%0d", bus_if.tx_data, bus_if.tx_esc);
          chk("tx_data", 32'(bus_if.tx_data), 32'(e[7:0]));
          chk("tx_esc", 32'(bus_if.tx_esc), 32'(e[8]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic s, input logic e, input logic [7:0] d);
    bus_if.dec_data  = d;
    bus_if.dec_start = s;
    bus_if.dec_end   = e;
    bus_if.dec_drdy  = 1'b1;
    repeat (2) tick();
    bus_if.dec_drdy  = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_start();
    send_char(1'b1, 1'b0, 8'h00);
  endtask
  task automatic send_end();
    send_char(1'b0, 1'b1, 8'h00);
  endtask
  task automatic send_byte(input logic [7:0] d);
    send_char(1'b0, 1'b0, d);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      tick();
    end
    chk(tag, 32'(busy), 0);
    repeat (3) tick();
  endtask

  task automatic wait_tx_valid(input string tag, input logic esc);
    int n;
    n = 0;
    while (!(bus_if.tx_valid && bus_if.tx_esc == esc) && n < 500) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus_if.tx_valid), 1);
  endtask

  initial begin
    int e0, t0, r0, w0;
    logic [7:0] d;
    logic stable;

    for (int i = 0; i < 128; i++) regs[i] = 8'(i ^ 8'h5A);
    reset = 1'b1;
    bus_if.dec_drdy = 1'b0; bus_if.dec_data = 8'h00;
    bus_if.dec_start = 1'b0; bus_if.dec_end = 1'b0;
    bus_if.reg_rdata = 8'h00; bus_if.tx_ready = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_valid", 32'(bus_if.tx_valid), 0);
    chk("rst_we", 32'(bus_if.reg_we), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_addr", 32'(bus_if.reg_addr), 0);

    // Basic write.
    e0 = err_cnt; t0 = tx_cnt;
    wr_q.push_back({8'h05, 8'hAA}); wr_q.push_back({8'h06, 8'hBB});
    send_start(); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB); send_end();
    wait_idle("wr_idle");
    chk("wr_q_empty", 32'(wr_q.size()), 0);
    chk("wr_no_err", 32'(err_cnt - e0), 0);
    chk("wr_no_tx", 32'(tx_cnt - t0), 0);

    // Basic read of two registers.
    regs[8'h10] = 8'h11; regs[8'h11] = 8'h17;
    e0 = err_cnt;
    tx_q.push_back({1'b0, 8'h01}); tx_q.push_back({1'b1, 8'h11});
    tx_q.push_back({1'b1, 8'h17}); tx_q.push_back({1'b0, 8'h17});
    send_start(); send_byte(8'h90); send_byte(8'h02); send_end();
    wait_idle("rd_idle");
    chk("rd_q_empty", 32'(tx_q.size()), 0);
    chk("rd_no_err", 32'(err_cnt - e0), 0);

    // Read count 0.
    r0 = re_cnt;
    tx_q.push_back({1'b0, 8'h01}); tx_q.push_back({1'b0, 8'h17});
    send_start(); send_byte(8'hA0); send_byte(8'h00); send_end();
    wait_idle("cnt0_idle");
    chk("cnt0_q_empty", 32'(tx_q.size()), 0);
    chk("cnt0_no_re", 32'(re_cnt - r0), 0);

    // Read count clamp: 0xFF -> 16.
    r0 = re_cnt;
    tx_q.push_back({1'b0, 8'h01});
    for (int i = 0; i < 16; i++) begin
      regs[8'h30 + i] = 8'($urandom_range(0, 255));
      tx_q.push_back({1'b1, regs[8'h30 + i]});
    end
    tx_q.push_back({1'b0, 8'h17});
    send_start(); send_byte(8'hB0); send_byte(8'hFF); send_end();
    wait_idle("clamp_idle");
    chk("clamp_q_empty", 32'(tx_q.size()), 0);
    chk("clamp_re_cnt", 32'(re_cnt - r0), 16);

    // Backpressure during RDATA.
    regs[8'h40] = 8'h3C;
    tx_q.push_back({1'b0, 8'h01}); tx_q.push_back({1'b1, 8'h3C}); tx_q.push_back({1'b0, 8'h17});
    bus_if.tx_ready = 1'b0;
    send_start(); send_byte(8'hC0); send_byte(8'h01); send_end();
    wait_tx_valid("bp_rstart_valid", 1'b0);
    bus_if.tx_ready = 1'b1; tick(); bus_if.tx_ready = 1'b0;
    wait_tx_valid("bp_rdata_valid", 1'b1);
    d = bus_if.tx_data; r0 = re_cnt; stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!(bus_if.tx_valid && bus_if.tx_esc && bus_if.tx_data == d)) stable = 1'b0;
    end
    chk("bp_data", 32'(d), 32'h3C);
    chk("bp_stable", 32'(stable), 1);
    chk("bp_no_extra_re", 32'(re_cnt - r0), 0);
    t0 = tx_cnt;
    bus_if.tx_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_tx_after_release", 32'(tx_cnt - t0), 2);
    chk("bp_q_empty", 32'(tx_q.size()), 0);

    // Double START then write.
    e0 = err_cnt;
    wr_q.push_back({8'h03, 8'h01});
    send_start(); send_start(); send_byte(8'h03); send_byte(8'h01); send_end();
    wait_idle("dstart_idle");
    chk("dstart_err", 32'(err_cnt - e0), 1);
    chk("dstart_q_empty", 32'(wr_q.size()), 0);

    // Extra data byte in a read frame.
    e0 = err_cnt; t0 = tx_cnt;
    send_start(); send_byte(8'h90); send_byte(8'h02); send_byte(8'h55); send_end();
    wait_idle("extra_idle");
    chk("extra_err", 32'(err_cnt - e0), 1);
    chk("extra_no_tx", 32'(tx_cnt - t0), 0);

    // Address wrap on write.
    wr_q.push_back({8'h7F, 8'h12}); wr_q.push_back({8'h00, 8'h34});
    send_start(); send_byte(8'h7F); send_byte(8'h12); send_byte(8'h34); send_end();
    wait_idle("wrap_idle");
    chk("wrap_q_empty", 32'(wr_q.size()), 0);

    // Reset in the middle of RDATA.
    tx_q.push_back({1'b0, 8'h01});
    bus_if.tx_ready = 1'b0;
    send_start(); send_byte(8'h90); send_byte(8'h02); send_end();
    wait_tx_valid("rst_rstart_valid", 1'b0);
    bus_if.tx_ready = 1'b1; tick(); bus_if.tx_ready = 1'b0;
    wait_tx_valid("rst_rdata_valid", 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_tx_valid", 32'(bus_if.tx_valid), 0);
    tick();
    chk("rst_mid_busy", 32'(busy), 0);
    reset = 1'b0;
    bus_if.tx_ready = 1'b1;
    tick();
    chk("rst_mid_tx_valid2", 32'(bus_if.tx_valid), 0);
    chk("rst_mid_q_empty", 32'(tx_q.size()), 0);
    tx_q.delete();

`ifdef UNIBOARD_CMD_TIMEOUT_EN
    // Inter-character timeout.
    e0 = err_cnt; w0 = we_cnt;
    send_start(); send_byte(8'h05);
    for (int i = 0; i < 300; i++) begin
      if (err_cnt != e0) break;
      tick();
    end
    chk("to_err", 32'(err_cnt - e0), 1);
    chk("to_idle", 32'(busy), 0);
    send_byte(8'h22);
    repeat (4) tick();
    chk("to_ignored_we", 32'(we_cnt - w0), 0);
    chk("to_ignored_busy", 32'(busy), 0);
`else
    w0 = we_cnt;
    chk("final_we_total", 32'(w0), 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
